board_led_scan: RTL

- Downstream consumer of the game top level: takes the nine 2-bit cell states and the 2-bit winner code.
- Drives a row-multiplexed 3x3 bicolour LED matrix: red = player 1, green = player 2.
- Scans one row at a time. Once a result exists, blinks the winning player's cells (all lit cells on a draw).
- Output registers only. No handshake with the game logic; inputs are sampled every cycle.

---
 rtl/board_led_scan.sv | 135 +++++++++++++
 1 files changed

// File: rtl/board_led_scan.sv
// Row-multiplexed driver for a 3x3 bicolour LED board (red = player 1, green = player 2).
// Scans one row per SCAN_DIV cycles and blinks the winning cells once a result exists.
module board_led_scan #(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned BLINK_ROWS = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   input  logic [1:0] win,
   output logic [2:0] row_sel,
   output logic [2:0] red_col,
   output logic [2:0] grn_col,
   output logic       frame_tick
);

   localparam int unsigned DivW = $clog2(SCAN_DIV);
   localparam int unsigned BlkW = (BLINK_ROWS > 1) ? $clog2(BLINK_ROWS) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_ROWS - 1);

   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      row_q, row_d;
   logic [BlkW-1:0] blink_cnt_q, blink_cnt_d;
   logic            blink_on_q, blink_on_d;
   logic            wrap_q, wrap_d;
   logic [2:0]      row_sel_q, row_sel_d;
   logic [2:0]      red_q, red_d;
   logic [2:0]      grn_q, grn_d;
   logic            tick_q, tick_d;

   logic            advance;
   logic [1:0]      row_cells [3];
   logic            hide;

   always_comb begin : scan_next
      advance = (div_q == DivLast);
      div_d   = advance ? '0 : div_q + 1'b1;
      row_d   = row_q;
      wrap_d  = 1'b0;
      if (advance) begin
         if (row_q == 2'd2) begin
            row_d  = 2'd0;
            wrap_d = 1'b1;
         end else begin
            row_d = row_q + 2'd1;
         end
      end
   end

   always_comb begin : blink_next
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (win == 2'b00) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (advance) begin
         if (blink_cnt_q == BlkLast) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin : out_next
      case (row_q)
         2'd0: begin
            row_cells = '{pos1, pos2, pos3};
            row_sel_d = 3'b001;
         end
         2'd1: begin
            row_cells = '{pos4, pos5, pos6};
            row_sel_d = 3'b010;
         end
         default: begin
            row_cells = '{pos7, pos8, pos9};
            row_sel_d = 3'b100;
         end
      endcase

      // Invalid cells (11) never match 01/10, so they stay dark in every case.
      hide  = 1'b0;
      red_d = 3'b000;
      grn_d = 3'b000;
      for (int c = 0; c < 3; c++) begin
         hide     = ~blink_on_q &
                    ((win == 2'b11) | ((win != 2'b00) & (row_cells[c] == win)));
         red_d[c] = (row_cells[c] == 2'b01) & ~hide;
         grn_d[c] = (row_cells[c] == 2'b10) & ~hide;
      end

      // Delayed one extra cycle so the tick lines up with row_sel returning to row 0.
      tick_d = wrap_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q       <= '0;
         row_q       <= 2'd0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         wrap_q      <= 1'b0;
         row_sel_q   <= 3'b000;
         red_q       <= 3'b000;
         grn_q       <= 3'b000;
         tick_q      <= 1'b0;
      end else begin
         div_q       <= div_d;
         row_q       <= row_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         wrap_q      <= wrap_d;
         row_sel_q   <= row_sel_d;
         red_q       <= red_d;
         grn_q       <= grn_d;
         tick_q      <= tick_d;
      end
   end

   assign row_sel    = row_sel_q;
   assign red_col    = red_q;
   assign grn_col    = grn_q;
   assign frame_tick = tick_q;

endmodule
